// File: rtl/write_scheduler.sv
// ---------------------------------------------------------------------------
// write_scheduler
//
// Front-end scheduler for a multi-port write RAM. NB_WRAGENT valid/ready
// write agents each own one RAM write port. Agents that present the same
// address in the same cycle are arbitrated round-robin: one wins and the
// others stall through agt_ready. Agents with distinct addresses all proceed
// in parallel. RAM-side outputs are registered, so an accepted request is
// presented to the RAM on the following cycle. Two enabled ports never carry
// the same address in one cycle.
//
// Optional feature macro: WRSCHED_STATS_EN
//   When defined, a saturating collision_cnt output counts cycles in which
//   at least one agent stalled. When undefined, the port and its counter are
//   absent and all other behaviour is unchanged.
//
// Parameters
//   ADDR_WIDTH  write address width
//   DATA_WIDTH  write data width
//   NB_WRAGENT  number of write agents / RAM write ports (>= 2)
//   CNT_WIDTH   collision counter width (only used with WRSCHED_STATS_EN)
//
// Ports
//   aclk           in   clock, rising edge
//   aresetn        in   asynchronous active-low reset
//   agt_valid      in   per-agent write request
//   agt_ready      out  per-agent accept (combinational)
//   agt_addr       in   agent i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   agt_data       in   agent i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   wren           out  RAM write enable, port i driven by agent i
//   wraddr         out  RAM write address, same packing as agt_addr
//   wrdata         out  RAM write data, same packing as agt_data
//   collision      out  registered: some request stalled in the previous cycle
//   collision_cnt  out  saturating stall-cycle counter (WRSCHED_STATS_EN only)
// ---------------------------------------------------------------------------
module write_scheduler #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int NB_WRAGENT = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NB_WRAGENT-1:0]            agt_valid,
  output logic [NB_WRAGENT-1:0]            agt_ready,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] agt_addr,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0] agt_data,
  output logic [NB_WRAGENT-1:0]            wren,
  output logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
  output logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata,
`ifdef WRSCHED_STATS_EN
  output logic [CNT_WIDTH-1:0]             collision_cnt,
`endif
  output logic                             collision
);

  localparam int PTR_WIDTH = (NB_WRAGENT > 1) ? $clog2(NB_WRAGENT) : 1;

  logic [PTR_WIDTH-1:0]            r_rrPtr;
  logic [NB_WRAGENT-1:0]           r_wren;
  logic [NB_WRAGENT*ADDR_WIDTH-1:0] r_wraddr;
  logic [NB_WRAGENT*DATA_WIDTH-1:0] r_wrdata;
  logic                            r_collision;

  logic [NB_WRAGENT-1:0]           w_beaten;
  logic [NB_WRAGENT-1:0]           w_grant;
  logic [NB_WRAGENT-1:0]           w_xfer;
  logic                            w_stall;

  // Position of agent idx in the current priority order; 0 is the agent the
  // round-robin pointer names, higher numbers lose to lower ones.
  function automatic int rankOf(input int idx, input logic [PTR_WIDTH-1:0] ptr);
    int p;
    p = int'(ptr);
    if (idx >= p) return idx - p;
    else          return idx + NB_WRAGENT - p;
  endfunction

  // An agent loses if any other valid agent targets the same address and sits
  // earlier in the priority order. Every address group is resolved at once
  // against the same pointer, so each group yields exactly one winner.
  always_comb begin
    w_beaten = '0;
    for (int i = 0; i < NB_WRAGENT; i++) begin
      for (int j = 0; j < NB_WRAGENT; j++) begin
        if ((j != i) && agt_valid[i] && agt_valid[j] &&
            (agt_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == agt_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
            (rankOf(j, r_rrPtr) < rankOf(i, r_rrPtr))) begin
          w_beaten[i] = 1'b1;
        end
      end
    end
  end

  assign w_grant = agt_valid & ~w_beaten;

  // Ready is masked by reset so nothing is accepted while aresetn is low.
  assign agt_ready = w_grant & {NB_WRAGENT{aresetn}};
  assign w_xfer    = agt_valid & agt_ready;
  assign w_stall   = |(agt_valid & ~w_grant);

  // Write-port registers. Ports without a transfer drop wren but keep their
  // last address/data so the RAM bus does not toggle needlessly.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wren      <= '0;
      r_wraddr    <= '0;
      r_wrdata    <= '0;
      r_collision <= 1'b0;
    end else begin
      r_wren      <= w_xfer;
      r_collision <= w_stall;
      for (int i = 0; i < NB_WRAGENT; i++) begin
        if (w_xfer[i]) begin
          r_wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] <= agt_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          r_wrdata[i*DATA_WIDTH +: DATA_WIDTH] <= agt_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // The pointer only moves when someone stalled; this rotates priority among
  // contenders and bounds the wait of a persistent requester to NB_WRAGENT
  // collision cycles.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rrPtr <= '0;
    end else if (w_stall) begin
      if (r_rrPtr == PTR_WIDTH'(NB_WRAGENT - 1)) r_rrPtr <= '0;
      else                                        r_rrPtr <= r_rrPtr + PTR_WIDTH'(1);
    end
  end

`ifdef WRSCHED_STATS_EN
  logic [CNT_WIDTH-1:0] r_collisionCnt;

  // Saturating count of stall cycles; sticks at all-ones instead of wrapping.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_collisionCnt <= '0;
    end else if (w_stall && (r_collisionCnt != '1)) begin
      r_collisionCnt <= r_collisionCnt + CNT_WIDTH'(1);
    end
  end

  assign collision_cnt = r_collisionCnt;
`endif

  assign wren      = r_wren;
  assign wraddr    = r_wraddr;
  assign wrdata    = r_wrdata;
  assign collision = r_collision;

endmodule
